// File: rtl/circle_pkg.sv
// rtl/circle_pkg.sv - shared state type and constants for the circle drawing block
//
// Purpose: state encoding for circle_ctrl plus octant count and screen
// geometry constants shared with the surrounding datapath.
// Ports: none (package).
package circle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    CHECK,
    PLOT,
    UPDATE,
    DONE
  } circ_state_t;

  localparam int N_OCTANTS = 8;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

endpackage

// File: rtl/circle_ctrl.sv
// rtl/circle_ctrl.sv - control FSM sequencing fillscreen and the octant Bresenham loop
//
// Purpose: on start, optionally clears the screen, loads the offset/crit
// registers, then loops CHECK -> 8x PLOT -> UPDATE until offset_y > offset_x,
// and holds done until start is released. Generates no pixels itself.
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   start / done              level handshake with the top level
//   fill_start / fill_done    fillscreen request / completion
//   draw_circle, octant_sel   circle path select and octant index (PLOT)
//   load_x, load_y, load_crit datapath initialisation strobes (LOAD)
//   inc_y, dec_x, calc_crit   datapath step strobes (UPDATE)
//   offset_x, offset_y, crit  signed feedback from the datapath
module circle_ctrl
  import circle_pkg::*;
#(
  parameter int OFFSET_X_DW = 9,
  parameter int OFFSET_Y_DW = 8,
  parameter int CRIT_DW     = 9,
  parameter bit CLEAR_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  output logic                   done,
  output logic                   fill_start,
  input  logic                   fill_done,
  output logic                   draw_circle,
  output logic [2:0]             octant_sel,
  output logic                   load_x,
  output logic                   load_y,
  output logic                   load_crit,
  output logic                   inc_y,
  output logic                   dec_x,
  output logic                   calc_crit,
  input  logic [OFFSET_X_DW-1:0] offset_x,
  input  logic [OFFSET_Y_DW-1:0] offset_y,
  input  logic [CRIT_DW-1:0]     crit
);

  localparam int CMP_DW = (OFFSET_X_DW > OFFSET_Y_DW) ? OFFSET_X_DW : OFFSET_Y_DW;
  localparam logic [2:0] LAST_OCT = 3'(N_OCTANTS - 1);

  circ_state_t state;
  logic [2:0]  oct_cnt;

  // Both offsets are sign-extended to a common width before comparing, since
  // offset_x goes negative (-1) when radius is 0.
  logic signed [CMP_DW-1:0] x_ext;
  logic signed [CMP_DW-1:0] y_ext;
  logic                     y_le_x;
  logic                     crit_pos;

  assign x_ext    = CMP_DW'($signed(offset_x));
  assign y_ext    = CMP_DW'($signed(offset_y));
  assign y_le_x   = (y_ext <= x_ext);
  assign crit_pos = !crit[CRIT_DW-1] && (crit != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      oct_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= CLEAR_EN ? CLEAR : LOAD;
        end
        CLEAR: begin
          if (fill_done) state <= LOAD;
        end
        LOAD: begin
          state <= CHECK;
        end
        CHECK: begin
          oct_cnt <= '0;
          state   <= y_le_x ? PLOT : DONE;
        end
        PLOT: begin
          // oct_cnt wraps back to 0 on the last octant by natural overflow
          oct_cnt <= oct_cnt + 3'd1;
          if (oct_cnt == LAST_OCT) state <= UPDATE;
        end
        UPDATE: begin
          state <= CHECK;
        end
        DONE: begin
          // stay here while start is held so a held request cannot re-trigger
          if (!start) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          oct_cnt <= '0;
        end
      endcase
    end
  end

  // Moore decode; dec_x is the only output that also looks at an input.
  always_comb begin
    done        = 1'b0;
    fill_start  = 1'b0;
    draw_circle = 1'b0;
    octant_sel  = 3'd0;
    load_x      = 1'b0;
    load_y      = 1'b0;
    load_crit   = 1'b0;
    inc_y       = 1'b0;
    dec_x       = 1'b0;
    calc_crit   = 1'b0;
    case (state)
      CLEAR: fill_start = 1'b1;
      LOAD: begin
        load_x    = 1'b1;
        load_y    = 1'b1;
        load_crit = 1'b1;
      end
      PLOT: begin
        draw_circle = 1'b1;
        octant_sel  = oct_cnt;
      end
      UPDATE: begin
        inc_y     = 1'b1;
        calc_crit = 1'b1;
        dec_x     = crit_pos;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
